// File: rtl/cheri_mem_arbiter.sv
// cheri_mem_arbiter: shares one single-port RAM between a tsmap reader, a data port and an instruction port.
// Latency: grants are combinational in the request cycle; rvalid/err/rdata follow exactly one cycle later.
// Backpressure: tsmap is never stalled; data/instr wait (gnt=0) while a higher-priority requester owns the RAM.
//
// Ports:
//   clk_i, rstn_i                    clock, asynchronous active-low reset
//   tsmap_cs_i/addr_i/rdata_o        tsmap read port (word address), highest priority, no grant handshake
//   data_req_i/gnt_o/rvalid_o/err_o  data port handshake and response
//   data_we_i/be_i/addr_i/wdata_i    data access attributes (byte address)
//   data_rdata_o                     data read data
//   instr_req_i/gnt_o/rvalid_o/err_o instruction port handshake and response
//   instr_addr_i/rdata_o             instruction byte address and read data
//   ram_cs_o/we_o/be_o/addr_o/wdata_o  RAM command (word address)
//   ram_rdata_i                      RAM read data, valid one cycle after ram_cs_o

module cheri_mem_arbiter #(
  parameter int unsigned DataWidth   = 33,
  parameter logic [31:0] RamBase     = 32'h200f_0000,
  parameter int unsigned RamAw       = 14,
  parameter int unsigned StarveLimit = 8
) (
  input  logic                 clk_i,
  input  logic                 rstn_i,

  input  logic                 tsmap_cs_i,
  input  logic [RamAw-1:0]     tsmap_addr_i,
  output logic [DataWidth-1:0] tsmap_rdata_o,

  input  logic                 data_req_i,
  output logic                 data_gnt_o,
  output logic                 data_rvalid_o,
  output logic                 data_err_o,
  input  logic                 data_we_i,
  input  logic [3:0]           data_be_i,
  input  logic [31:0]          data_addr_i,
  input  logic [DataWidth-1:0] data_wdata_i,
  output logic [DataWidth-1:0] data_rdata_o,

  input  logic                 instr_req_i,
  output logic                 instr_gnt_o,
  output logic                 instr_rvalid_o,
  output logic                 instr_err_o,
  input  logic [31:0]          instr_addr_i,
  output logic [DataWidth-1:0] instr_rdata_o,

  output logic                 ram_cs_o,
  output logic                 ram_we_o,
  output logic [3:0]           ram_be_o,
  output logic [RamAw-1:0]     ram_addr_o,
  output logic [DataWidth-1:0] ram_wdata_o,
  input  logic [DataWidth-1:0] ram_rdata_i
);

  localparam int unsigned CntW = $clog2(StarveLimit + 1);
  localparam logic [CntW-1:0] CntMax = CntW'(StarveLimit);
  // One past the last RAM byte, computed in 33 bits so a RAM ending at 4 GiB does not wrap.
  localparam logic [32:0] RamEnd = {1'b0, RamBase} + (33'd1 << (RamAw + 2));

  // Who owns the response slot in the cycle after a grant.
  typedef enum logic [1:0] {
    OWN_NONE  = 2'd0,
    OWN_DATA  = 2'd1,
    OWN_INSTR = 2'd2
  } owner_e;

  function automatic logic f_in_range(input logic [31:0] a);
    return (a >= RamBase) && ({1'b0, a} < RamEnd);
  endfunction

  function automatic logic [RamAw-1:0] f_word(input logic [31:0] a);
    return RamAw'((a - RamBase) >> 2);
  endfunction

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  owner_e          r_owner;
  logic            r_err;
  logic            r_we;
  logic            r_ts_pend;
  logic [CntW-1:0] r_starve;

  // --------------------------------------------------------------------------
  // Arbitration
  // --------------------------------------------------------------------------
  logic             w_ts_sel;
  logic             w_promote;
  logic             w_data_gnt;
  logic             w_instr_gnt;
  logic             w_data_inr;
  logic             w_instr_inr;
  logic [RamAw-1:0] w_data_word;
  logic [RamAw-1:0] w_instr_word;

  // Grants are forced low during reset so nothing downstream sees a handshake.
  assign w_ts_sel    = rstn_i & tsmap_cs_i;
  assign w_promote   = (r_starve == CntMax);
  assign w_data_gnt  = rstn_i & ~tsmap_cs_i & data_req_i  & ~(w_promote & instr_req_i);
  assign w_instr_gnt = rstn_i & ~tsmap_cs_i & instr_req_i & (w_promote | ~data_req_i);

  assign w_data_inr   = f_in_range(data_addr_i);
  assign w_instr_inr  = f_in_range(instr_addr_i);
  assign w_data_word  = f_word(data_addr_i);
  assign w_instr_word = f_word(instr_addr_i);

  assign data_gnt_o  = w_data_gnt;
  assign instr_gnt_o = w_instr_gnt;

  // --------------------------------------------------------------------------
  // RAM command: out-of-range grants are answered with err and never touch the RAM.
  // --------------------------------------------------------------------------
  logic                 w_ram_cs;
  logic                 w_ram_we;
  logic [3:0]           w_ram_be;
  logic [RamAw-1:0]     w_ram_addr;
  logic [DataWidth-1:0] w_ram_wdata;

  always_comb begin
    w_ram_cs    = 1'b0;
    w_ram_we    = 1'b0;
    w_ram_be    = 4'h0;
    w_ram_addr  = '0;
    w_ram_wdata = '0;
    if (w_ts_sel) begin
      w_ram_cs   = 1'b1;
      w_ram_be   = 4'hF;
      w_ram_addr = tsmap_addr_i;
    end else if (w_data_gnt && w_data_inr) begin
      w_ram_cs    = 1'b1;
      w_ram_we    = data_we_i;
      w_ram_be    = data_be_i;
      w_ram_addr  = w_data_word;
      w_ram_wdata = data_wdata_i;
    end else if (w_instr_gnt && w_instr_inr) begin
      w_ram_cs   = 1'b1;
      w_ram_be   = 4'hF;
      w_ram_addr = w_instr_word;
    end
  end

  assign ram_cs_o    = w_ram_cs;
  assign ram_we_o    = w_ram_we;
  assign ram_be_o    = w_ram_be;
  assign ram_addr_o  = w_ram_addr;
  assign ram_wdata_o = w_ram_wdata;

  // --------------------------------------------------------------------------
  // Response slot and starvation counter
  // --------------------------------------------------------------------------
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_owner   <= OWN_NONE;
      r_err     <= 1'b0;
      r_we      <= 1'b0;
      r_ts_pend <= 1'b0;
      r_starve  <= '0;
    end else begin
      r_ts_pend <= tsmap_cs_i;

      if (w_data_gnt) begin
        r_owner <= OWN_DATA;
        r_err   <= ~w_data_inr;
        r_we    <= data_we_i;
      end else if (w_instr_gnt) begin
        r_owner <= OWN_INSTR;
        r_err   <= ~w_instr_inr;
        r_we    <= 1'b0;
      end else begin
        r_owner <= OWN_NONE;
        r_err   <= 1'b0;
        r_we    <= 1'b0;
      end

      // Counts only consecutive denied cycles; saturates so tsmap can keep
      // winning without the promotion being lost.
      if (instr_req_i && !w_instr_gnt) begin
        if (r_starve != CntMax) begin
          r_starve <= r_starve + 1'b1;
        end
      end else begin
        r_starve <= '0;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Response outputs: read data is only passed through for error-free reads.
  // --------------------------------------------------------------------------
  logic w_data_rsp;
  logic w_instr_rsp;

  assign w_data_rsp  = (r_owner == OWN_DATA);
  assign w_instr_rsp = (r_owner == OWN_INSTR);

  assign data_rvalid_o  = w_data_rsp;
  assign data_err_o     = w_data_rsp & r_err;
  assign data_rdata_o   = (w_data_rsp && !r_err && !r_we) ? ram_rdata_i : '0;

  assign instr_rvalid_o = w_instr_rsp;
  assign instr_err_o    = w_instr_rsp & r_err;
  assign instr_rdata_o  = (w_instr_rsp && !r_err) ? ram_rdata_i : '0;

  assign tsmap_rdata_o  = r_ts_pend ? ram_rdata_i : '0;

endmodule

// File: tb/tb_cheri_mem_arbiter.sv
// tb_cheri_mem_arbiter: directed scenarios plus randomized traffic checked every cycle
// against a transaction-level model of the arbiter (winner pick, address decode, one-cycle response).
// Inputs change 1ns after the rising edge; outputs are sampled on the falling edge.

module tb_cheri_mem_arbiter;

  localparam int          DW   = 33;
  localparam logic [31:0] BASE = 32'h200f_0000;
  localparam int          AW   = 14;
  localparam int          LIM  = 8;

  logic          clk_i = 1'b0;
  logic          rstn_i;
  logic          tsmap_cs_i;
  logic [AW-1:0] tsmap_addr_i;
  logic [DW-1:0] tsmap_rdata_o;
  logic          data_req_i, data_gnt_o, data_rvalid_o, data_err_o, data_we_i;
  logic [3:0]    data_be_i;
  logic [31:0]   data_addr_i;
  logic [DW-1:0] data_wdata_i, data_rdata_o;
  logic          instr_req_i, instr_gnt_o, instr_rvalid_o, instr_err_o;
  logic [31:0]   instr_addr_i;
  logic [DW-1:0] instr_rdata_o;
  logic          ram_cs_o, ram_we_o;
  logic [3:0]    ram_be_o;
  logic [AW-1:0] ram_addr_o;
  logic [DW-1:0] ram_wdata_o, ram_rdata_i;

  cheri_mem_arbiter #(
    .DataWidth(DW), .RamBase(BASE), .RamAw(AW), .StarveLimit(LIM)
  ) dut (
    .clk_i(clk_i), .rstn_i(rstn_i),
    .tsmap_cs_i(tsmap_cs_i), .tsmap_addr_i(tsmap_addr_i), .tsmap_rdata_o(tsmap_rdata_o),
    .data_req_i(data_req_i), .data_gnt_o(data_gnt_o), .data_rvalid_o(data_rvalid_o),
    .data_err_o(data_err_o), .data_we_i(data_we_i), .data_be_i(data_be_i),
    .data_addr_i(data_addr_i), .data_wdata_i(data_wdata_i), .data_rdata_o(data_rdata_o),
    .instr_req_i(instr_req_i), .instr_gnt_o(instr_gnt_o), .instr_rvalid_o(instr_rvalid_o),
    .instr_err_o(instr_err_o), .instr_addr_i(instr_addr_i), .instr_rdata_o(instr_rdata_o),
    .ram_cs_o(ram_cs_o), .ram_we_o(ram_we_o), .ram_be_o(ram_be_o), .ram_addr_o(ram_addr_o),
    .ram_wdata_o(ram_wdata_o), .ram_rdata_i(ram_rdata_i)
  );

  always #5 clk_i = ~clk_i;

  int n_vec = 0;
  int n_err = 0;

  // Model state: starvation count and the response promised for the next cycle.
  int            m_starve = 0;
  int            p_own    = 0;   // 0 none, 1 data, 2 instr
  bit            p_err    = 1'b0;
  bit            p_we     = 1'b0;
  bit            p_ts     = 1'b0;
  logic [DW-1:0] cur_rd;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic bit in_rng(input logic [31:0] a);
    longint la, lb;
    la = longint'(a);
    lb = longint'(BASE);
    return (la >= lb) && (la < lb + 4 * (longint'(1) << AW));
  endfunction

  function automatic logic [AW-1:0] mword(input logic [31:0] a);
    longint off;
    off = (longint'(a) - longint'(BASE)) / 4;
    return AW'(off);
  endfunction

  function automatic logic [31:0] rnd_addr();
    case ($urandom_range(0, 5))
      0:       return BASE + 32'(($urandom_range(0, (1 << AW) - 1)) * 4);
      1:       return BASE + 32'((1 << AW) * 4) - 32'd4;
      2:       return BASE + 32'((1 << AW) * 4);
      3:       return BASE - 32'd4;
      4:       return BASE;
      default: return $urandom();
    endcase
  endfunction

  function automatic logic [DW-1:0] rnd_word();
    logic [63:0] t;
    t = {$urandom(), $urandom()};
    return t[DW-1:0];
  endfunction

  // One clock of stimulus followed by a full comparison against the model.
  task automatic cycle(input bit rn, input bit ts, input logic [AW-1:0] ta,
                       input bit dr, input bit dw, input logic [3:0] dbe,
                       input logic [31:0] da, input logic [DW-1:0] dwd,
                       input bit ir, input logic [31:0] ia);
    int            win;  // 0 none, 1 tsmap, 2 data, 3 instr
    bit            e_cs, e_we, ck_be, ck_wd, ck_ad;
    logic [3:0]    e_be;
    logic [AW-1:0] e_ad;
    logic [DW-1:0] e_wd;
    bit            e_dv, e_iv;
    @(posedge clk_i);
    #1;
    rstn_i = rn; tsmap_cs_i = ts; tsmap_addr_i = ta;
    data_req_i = dr; data_we_i = dw; data_be_i = dbe; data_addr_i = da; data_wdata_i = dwd;
    instr_req_i = ir; instr_addr_i = ia;
    cur_rd = rnd_word();
    ram_rdata_i = cur_rd;
    @(negedge clk_i);

    if (!rn)                   win = 0;
    else if (ts)               win = 1;
    else if (dr && ir)         win = (m_starve >= LIM) ? 3 : 2;
    else if (dr)               win = 2;
    else if (ir)               win = 3;
    else                       win = 0;

    e_cs = 0; e_we = 0; e_be = 4'h0; e_ad = '0; e_wd = '0;
    ck_be = 1; ck_wd = 1; ck_ad = 1;
    if (win == 1) begin
      e_cs = 1; e_ad = ta; ck_be = 0; ck_wd = 0;
    end else if (win == 2 && in_rng(da)) begin
      e_cs = 1; e_we = dw; e_be = dbe; e_ad = mword(da); e_wd = dwd;
    end else if (win == 3 && in_rng(ia)) begin
      e_cs = 1; e_be = 4'hF; e_ad = mword(ia); ck_wd = 0;
    end else if (rn) begin
      ck_ad = 0;
    end

    chk("data_gnt", data_gnt_o, rn && win == 2);
    chk("instr_gnt", instr_gnt_o, rn && win == 3);
    chk("ram_cs", ram_cs_o, e_cs);
    chk("ram_we", ram_we_o, e_we);
    if (ck_be) chk("ram_be", ram_be_o, e_be);
    if (ck_wd) chk("ram_wdata", ram_wdata_o, e_wd);
    if (ck_ad) chk("ram_addr", ram_addr_o, e_ad);

    e_dv = rn && p_own == 1;
    e_iv = rn && p_own == 2;
    chk("data_rvalid", data_rvalid_o, e_dv);
    chk("data_err", data_err_o, e_dv && p_err);
    chk("data_rdata", data_rdata_o, (e_dv && !p_err && !p_we) ? cur_rd : '0);
    chk("instr_rvalid", instr_rvalid_o, e_iv);
    chk("instr_err", instr_err_o, e_iv && p_err);
    chk("instr_rdata", instr_rdata_o, (e_iv && !p_err) ? cur_rd : '0);
    chk("tsmap_rdata", tsmap_rdata_o, (rn && p_ts) ? cur_rd : '0);

    if (!rn) begin
      m_starve = 0; p_own = 0; p_err = 0; p_we = 0; p_ts = 0;
    end else begin
      p_ts  = ts;
      p_own = (win == 2) ? 1 : (win == 3) ? 2 : 0;
      p_err = (win == 2) ? !in_rng(da) : (win == 3) ? !in_rng(ia) : 1'b0;
      p_we  = (win == 2) && dw;
      if (ir && win != 3) m_starve = (m_starve + 1 > LIM) ? LIM : m_starve + 1;
      else                m_starve = 0;
    end
  endtask

  task automatic idle();
    cycle(1, 0, '0, 0, 0, 4'h0, 32'h0, '0, 0, 32'h0);
  endtask

  task automatic both(input bit rn);
    cycle(rn, 0, '0, 1, 0, 4'hF, BASE + 32'h40, '0, 1, BASE + 32'h80);
  endtask

  localparam logic [31:0] TOP = 32'h2010_0000;

  initial begin
    rstn_i = 0; tsmap_cs_i = 0; tsmap_addr_i = '0; data_req_i = 0; data_we_i = 0;
    data_be_i = '0; data_addr_i = '0; data_wdata_i = '0; instr_req_i = 0;
    instr_addr_i = '0; ram_rdata_i = '0; cur_rd = '0;

    // Reset with every requester active: everything must stay quiet.
    cycle(0, 1, 14'h0123, 1, 1, 4'hF, BASE, 33'h1_2345_6789, 1, BASE);
    chk("rst_cs_lit", ram_cs_o, 0);
    chk("rst_gnt_lit", data_gnt_o | instr_gnt_o, 0);
    cycle(0, 0, '0, 1, 0, 4'hF, BASE, '0, 0, '0);
    idle();
    chk("post_rst_rvalid_lit", data_rvalid_o | instr_rvalid_o, 0);

    // Data read at 0x200f_0010.
    cycle(1, 0, '0, 1, 0, 4'hF, 32'h200f_0010, '0, 0, '0);
    chk("rd_gnt_lit", data_gnt_o, 1);
    chk("rd_addr_lit", ram_addr_o, 4);
    idle();
    chk("rd_rvalid_lit", data_rvalid_o, 1);
    chk("rd_rdata_lit", data_rdata_o, cur_rd);

    // All three requesters at once.
    cycle(1, 1, 14'h2aa, 1, 0, 4'hF, BASE + 32'h8, '0, 1, BASE + 32'hc);
    chk("all3_gnt_lit", {data_gnt_o, instr_gnt_o}, 2'b00);
    chk("all3_addr_lit", ram_addr_o, 14'h2aa);
    idle();
    chk("all3_ts_rdata_lit", tsmap_rdata_o, cur_rd);

    // Partial write.
    cycle(1, 0, '0, 1, 1, 4'b0011, BASE + 32'h100, 33'h1_dead_beef, 0, '0);
    chk("wr_we_lit", ram_we_o, 1);
    chk("wr_be_lit", ram_be_o, 4'b0011);
    idle();
    chk("wr_rvalid_lit", data_rvalid_o, 1);
    chk("wr_rdata_lit", data_rdata_o, 0);

    // Instruction fetch just past the RAM.
    cycle(1, 0, '0, 0, 0, 4'h0, '0, '0, 1, TOP);
    chk("oor_gnt_lit", instr_gnt_o, 1);
    chk("oor_cs_lit", ram_cs_o, 0);
    idle();
    chk("oor_err_lit", {instr_rvalid_o, instr_err_o}, 2'b11);
    chk("oor_rdata_lit", instr_rdata_o, 0);

    // Address boundaries.
    cycle(1, 0, '0, 0, 0, 4'h0, '0, '0, 1, TOP - 32'd4);
    chk("last_word_lit", {ram_cs_o, ram_addr_o}, {1'b1, 14'h3fff});
    cycle(1, 0, '0, 1, 0, 4'hF, BASE - 32'd4, '0, 0, '0);
    chk("below_base_lit", {data_gnt_o, ram_cs_o}, 2'b10);
    idle();
    chk("below_base_err_lit", data_err_o, 1);

    // Starvation: eight data grants, then the instruction port, then data again.
    idle();
    for (int i = 0; i < 10; i++) begin
      both(1);
      if (i == 8) chk("starve_instr_lit", {data_gnt_o, instr_gnt_o}, 2'b01);
      else        chk("starve_data_lit", {data_gnt_o, instr_gnt_o}, 2'b10);
    end

    // Reset with a data response outstanding and a partly built starve count.
    idle();
    for (int i = 0; i < 5; i++) both(1);
    both(0);
    chk("rst_drop_rvalid_lit", data_rvalid_o, 0);
    for (int i = 0; i < 9; i++) begin
      both(1);
      if (i == 0) chk("rst_release_rvalid_lit", data_rvalid_o, 0);
      if (i == 8) chk("rst_starve_instr_lit", instr_gnt_o, 1);
      else        chk("rst_starve_data_lit", data_gnt_o, 1);
    end

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      cycle(($urandom_range(0, 63) != 0), ($urandom_range(0, 3) == 0), AW'($urandom()),
            $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1, 4'($urandom()),
            rnd_addr(), rnd_word(), $urandom_range(0, 2) != 0, rnd_addr());
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
